// File: rtl/mux_big_arbiter.sv
// Round-robin scheduler sharing one mux_big among C_INPUTS requesters, with a tag pipe
// aligned to the mux latency. Define MUX_BIG_ARBITER_SEQ_EN to add the out_seq beat counter.
module mux_big_arbiter #(
    parameter int unsigned C_WIDTH   = 32,
    parameter int unsigned C_INPUTS  = 4,
    parameter int unsigned C_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [C_INPUTS-1:0]         req,
    output logic [C_INPUTS-1:0]         ack,
    output logic                        mux_enable,
    output logic [$clog2(C_INPUTS)-1:0] mux_selector,
    input  logic [C_WIDTH-1:0]          mux_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(C_INPUTS)-1:0] out_index,
    output logic [C_WIDTH-1:0]          out_value
`ifdef MUX_BIG_ARBITER_SEQ_EN
    ,
    output logic [15:0]                 out_seq
`endif
);

    localparam int unsigned IdxW = $clog2(C_INPUTS);
    localparam int unsigned Last = C_LATENCY - 1;

    logic                tag_vld_q [C_LATENCY];
    logic                tag_vld_d [C_LATENCY];
    logic [IdxW-1:0]     tag_idx_q [C_LATENCY];
    logic [IdxW-1:0]     tag_idx_d [C_LATENCY];
    logic [C_INPUTS-1:0] inflight_q, inflight_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     sel_q, sel_d;

    logic                accept;
    logic                issue;
    logic                found;
    logic [IdxW-1:0]     pick;
    logic [IdxW-1:0]     cand;
    logic [C_INPUTS-1:0] accept_mask;
    logic [C_INPUTS-1:0] eligible;

    assign out_valid  = tag_vld_q[Last];
    assign out_index  = tag_idx_q[Last];
    assign out_value  = mux_value;
    assign mux_enable = ~(out_valid & ~out_ready);
    assign accept     = out_valid & out_ready;
    assign ack        = accept_mask;

    always_comb begin
        accept_mask = '0;
        if (accept) begin
            accept_mask[out_index] = 1'b1;
        end
    end

    // The beat being accepted is excluded so it cannot be re-issued in the same cycle.
    assign eligible = req & ~inflight_q & ~accept_mask;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= C_INPUTS; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % C_INPUTS);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign issue        = mux_enable & found;
    assign mux_selector = issue ? pick : sel_q;

    always_comb begin
        inflight_d = inflight_q;
        if (accept) begin
            inflight_d[out_index] = 1'b0;
        end
        if (issue) begin
            inflight_d[pick] = 1'b1;
        end
        ptr_d = issue ? pick : ptr_q;
        sel_d = issue ? pick : sel_q;
        for (int i = 0; i < int'(C_LATENCY); i++) begin
            tag_vld_d[i] = tag_vld_q[i];
            tag_idx_d[i] = tag_idx_q[i];
        end
        // Tag pipe advances in lockstep with mux_big, so it freezes on the same stall.
        if (mux_enable) begin
            tag_vld_d[0] = issue;
            tag_idx_d[0] = pick;
            for (int i = 1; i < int'(C_LATENCY); i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_idx_d[i] = tag_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(C_LATENCY); i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
            inflight_q <= '0;
            ptr_q      <= IdxW'(C_INPUTS - 1);
            sel_q      <= '0;
        end else begin
            for (int i = 0; i < int'(C_LATENCY); i++) begin
                tag_vld_q[i] <= tag_vld_d[i];
                tag_idx_q[i] <= tag_idx_d[i];
            end
            inflight_q <= inflight_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
        end
    end

`ifdef MUX_BIG_ARBITER_SEQ_EN
    logic [15:0] seq_q, seq_d;

    assign seq_d   = accept ? seq_q + 16'd1 : seq_q;
    assign out_seq = seq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_big_arbiter.sv
// Scoreboard bench for mux_big_arbiter with a behavioural mux_big model; the out_seq wrap
// check runs only when MUX_BIG_ARBITER_SEQ_EN is defined.
module tb_mux_big_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 2;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  ack;
    logic          mux_enable;
    logic [1:0]    mux_selector;
    logic [W-1:0]  mux_value;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_index;
    logic [W-1:0]  out_value;
`ifdef MUX_BIG_ARBITER_SEQ_EN
    logic [15:0]   out_seq;
    logic [15:0]   seq_exp = '0;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_acc   = 0;
    bit            sb_off  = 1'b0;
    exp_t          sb[$];
    logic [W-1:0]  vals [N] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
    logic [W-1:0]  mv_q [LAT];
    logic [N-1:0]  rearm      = '0;
    logic [N-1:0]  rearm_mask = '0;
    int            rearm_limit = 0;
    int            ack_cnt [N];

    mux_big_arbiter #(
        .C_WIDTH   (W),
        .C_INPUTS  (N),
        .C_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .ack          (ack),
        .mux_enable   (mux_enable),
        .mux_selector (mux_selector),
        .mux_value    (mux_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_value    (out_value)
`ifdef MUX_BIG_ARBITER_SEQ_EN
        ,
        .out_seq      (out_seq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural mux_big: LAT register stages, advancing only on enable.
    always @(posedge clk) begin
        if (mux_enable) begin
            mv_q[0] <= vals[mux_selector];
            for (int i = 1; i < LAT; i++) mv_q[i] <= mv_q[i-1];
        end
    end
    assign mux_value = mv_q[LAT-1];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (!sb_off) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_index), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("beat_index", 64'(out_index), 64'(e.idx));
                    chk("beat_value", 64'(out_value), 64'(e.val));
                    chk("beat_ack", 64'(ack), 64'(4'b0001 << e.idx));
                    if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
`ifdef MUX_BIG_ARBITER_SEQ_EN
            chk("out_seq", 64'(out_seq), 64'(seq_exp));
            seq_exp = seq_exp + 16'd1;
`endif
            n_acc++;
        end else begin
            chk("ack_idle", 64'(ack), 64'd0);
        end
    end

    task automatic push(input int idx, input int c);
        exp_t e;
        e.idx = 2'(idx);
        e.val = vals[idx];
        e.cyc = c;
        sb.push_back(e);
    endtask

    // One clock: requesters drop req after ack and optionally re-raise it a cycle later.
    task automatic step();
        logic [N-1:0] a;
        logic [N-1:0] nr;
        @(negedge clk);
        a = ack;
        @(posedge clk);
        #1;
        nr = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) ack_cnt[i]++;
            nr[i] = a[i] && rearm_mask[i] && (ack_cnt[i] < rearm_limit);
        end
        req   = (req & ~a) | rearm;
        rearm = nr;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst        = 1'b1;
        req        = r;
        rearm      = '0;
        rearm_mask = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
`ifdef MUX_BIG_ARBITER_SEQ_EN
        seq_exp = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_mux_selector", 64'(mux_selector), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 200) begin
            step();
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int c0;

        // Single requester, latency check.
        do_reset(4'b0000);
        c0  = cyc;
        req = 4'b0100;
        #1;
        chk("t1_sel", 64'(mux_selector), 64'd2);
        push(2, c0 + 2);
        drain();

        // All requesting: back-to-back issue and delivery.
        do_reset(4'b0000);
        c0  = cyc;
        req = 4'b1111;
        for (int i = 0; i < N; i++) push(i, c0 + 2 + i);
        for (int i = 0; i < N; i++) begin
            #1;
            chk("t2_sel", 64'(mux_selector), 64'(i));
            step();
        end
        drain();

        // Downstream stall for 5 cycles.
        do_reset(4'b0000);
        c0        = cyc;
        req       = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) push(i, c0 + 7 + i);
        #1;
        chk("t3_sel0", 64'(mux_selector), 64'd0);
        step();
        #1;
        chk("t3_sel1", 64'(mux_selector), 64'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_enable", 64'(mux_enable), 64'd0);
            chk("t3_index", 64'(out_index), 64'd0);
            chk("t3_value", 64'(out_value), 64'(vals[0]));
            chk("t3_sel_hold", 64'(mux_selector), 64'd1);
            step();
        end
        out_ready = 1'b1;
        drain();

        // Two re-raising requesters alternate.
        do_reset(4'b0000);
        c0          = cyc;
        req         = 4'b1001;
        rearm_mask  = 4'b1001;
        rearm_limit = 3;
        push(0, c0 + 2);
        push(3, c0 + 3);
        push(0, c0 + 6);
        push(3, c0 + 7);
        push(0, c0 + 10);
        push(3, c0 + 11);
        drain();

        // Reset with two beats in flight.
        do_reset(4'b0000);
        req = 4'b1111;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_valid_in_rst", 64'(out_valid), 64'd0);
        chk("t5_ack_in_rst", 64'(ack), 64'd0);
        do_reset(4'b1111);
        c0 = cyc;
        #1;
        chk("t5_first_sel", 64'(mux_selector), 64'd0);
        for (int i = 0; i < N; i++) push(i, c0 + 2 + i);
        drain();

`ifdef MUX_BIG_ARBITER_SEQ_EN
        // Sequence counter wrap over 65537 beats.
        sb_off = 1'b1;
        do_reset(4'b1111);
        n_acc       = 0;
        rearm_mask  = 4'b1111;
        rearm_limit = 32'h7FFF_FFFF;
        for (int k = 0; k < 70000 && n_acc < 65537; k++) step();
        chk("t6_seq_beats", 64'(n_acc >= 65537), 64'd1);
        rearm_mask = '0;
        repeat (10) step();
        sb_off = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
